// File: rtl/riscv_lsu_pkg.sv
// Shared encodings for the RISC-V load/store adapter: funct3 codes, FSM states
// and request legality helpers.
package riscv_lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_READ      = 3'd1,
      ST_LOAD_DATA = 3'd2,
      ST_MERGE     = 3'd3,
      ST_WRITE     = 3'd4,
      ST_RESP      = 3'd5
   } lsu_state_t;

   function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
      logic mis;
      case (funct3)
         F3_H, F3_HU: mis = addr_lo[0];
         F3_W:        mis = (addr_lo != 2'b00);
         default:     mis = 1'b0;
      endcase
      return mis;
   endfunction

   // Stores only know B/H/W; loads additionally accept the unsigned variants.
   function automatic logic is_illegal_funct3(input logic write, input logic [2:0] funct3);
      logic bad;
      case (funct3)
         F3_B, F3_H, F3_W: bad = 1'b0;
         F3_BU, F3_HU:     bad = write;
         default:          bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/riscv_lsu_adapter_lane_align.sv
// Little-endian lane handling: load extraction with sign/zero extension and
// sub-word store merge into an existing memory word.
module riscv_lane_align
   import riscv_lsu_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [31:0] i_wdata,
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_offset,
   output logic [31:0] o_load_data,
   output logic [31:0] o_store_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Select the addressed byte and halfword lanes of the memory word.
   always_comb begin
      case (i_offset)
         2'd0:    w_byte = i_word[7:0];
         2'd1:    w_byte = i_word[15:8];
         2'd2:    w_byte = i_word[23:16];
         default: w_byte = i_word[31:24];
      endcase
      if (i_offset[1]) begin
         w_half = i_word[31:16];
      end else begin
         w_half = i_word[15:0];
      end
   end

   // Extend the selected lane to 32 bits.
   always_comb begin
      case (i_funct3)
         F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
         F3_BU:   o_load_data = {24'h00_0000, w_byte};
         F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
         F3_HU:   o_load_data = {16'h0000, w_half};
         F3_W:    o_load_data = i_word;
         default: o_load_data = 32'h0000_0000;
      endcase
   end

   // Replace the addressed lane of the old word with the store data.
   always_comb begin
      o_store_data = i_word;
      case (i_funct3)
         F3_B: begin
            case (i_offset)
               2'd0:    o_store_data[7:0]   = i_wdata[7:0];
               2'd1:    o_store_data[15:8]  = i_wdata[7:0];
               2'd2:    o_store_data[23:16] = i_wdata[7:0];
               default: o_store_data[31:24] = i_wdata[7:0];
            endcase
         end
         F3_H: begin
            if (i_offset[1]) begin
               o_store_data[31:16] = i_wdata[15:0];
            end else begin
               o_store_data[15:0] = i_wdata[15:0];
            end
         end
         F3_W:    o_store_data = i_wdata;
         default: o_store_data = i_word;
      endcase
   end

endmodule

// File: rtl/riscv_lsu_adapter.sv
// Load/store adapter in front of a word-organised synchronous-read memory:
// word stores go straight out, sub-word stores read-modify-write, loads extract.
module riscv_lsu_adapter
   import riscv_lsu_pkg::*;
#(
   parameter int          PRINT_TRANSACTIONS = 0,
   parameter logic [31:0] ERROR_RDATA        = 32'h0000_0000
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic        rsp_error,
   output logic [31:0] rsp_rdata,
   output logic        mem_read_en,
   output logic        mem_write_en,
   output logic [31:0] mem_address,
   output logic [31:0] mem_write_data,
   input  logic [31:0] mem_read_data
);

   lsu_state_t  r_state;
   lsu_state_t  w_state_nxt;

   logic        r_write;
   logic [2:0]  r_funct3;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;

   logic        r_req_ready;
   logic        r_rsp_valid;
   logic        r_rsp_error;
   logic [31:0] r_rsp_rdata;
   logic        r_mem_read_en;
   logic        r_mem_write_en;
   logic [31:0] r_mem_address;
   logic [31:0] r_mem_write_data;

   logic        w_req_ready_nxt;
   logic        w_rsp_valid_nxt;
   logic        w_rsp_error_nxt;
   logic [31:0] w_rsp_rdata_nxt;
   logic        w_mem_read_en_nxt;
   logic        w_mem_write_en_nxt;
   logic [31:0] w_mem_address_nxt;
   logic [31:0] w_mem_write_data_nxt;

   logic        w_accept;
   logic        w_err;
   logic [31:0] w_load_data;
   logic [31:0] w_store_data;

   assign w_accept = (r_state == ST_IDLE) && req_valid;
   assign w_err    = is_misaligned(req_funct3, req_addr[1:0]) ||
                     is_illegal_funct3(req_write, req_funct3);

   riscv_lane_align u_lane_align (
      .i_word       (mem_read_data),
      .i_wdata      (r_wdata),
      .i_funct3     (r_funct3),
      .i_offset     (r_addr[1:0]),
      .o_load_data  (w_load_data),
      .o_store_data (w_store_data)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (!req_valid) begin
               w_state_nxt = ST_IDLE;
            end else if (w_err) begin
               w_state_nxt = ST_RESP;
            end else if (req_write && (req_funct3 == F3_W)) begin
               w_state_nxt = ST_WRITE;
            end else begin
               w_state_nxt = ST_READ;
            end
         end
         ST_READ: begin
            if (r_write) begin
               w_state_nxt = ST_MERGE;
            end else begin
               w_state_nxt = ST_LOAD_DATA;
            end
         end
         ST_LOAD_DATA: w_state_nxt = ST_IDLE;
         ST_MERGE:     w_state_nxt = ST_IDLE;
         ST_WRITE:     w_state_nxt = ST_IDLE;
         ST_RESP:      w_state_nxt = ST_IDLE;
         default:      w_state_nxt = ST_IDLE;
      endcase
   end

   // FSM output logic: next values of the registered outputs.
   always_comb begin
      w_rsp_valid_nxt = 1'b0;
      w_rsp_error_nxt = 1'b0;
      w_rsp_rdata_nxt = 32'h0000_0000;
      case (r_state)
         ST_IDLE: begin
            if (w_accept && w_err) begin
               w_rsp_valid_nxt = 1'b1;
               w_rsp_error_nxt = 1'b1;
               w_rsp_rdata_nxt = ERROR_RDATA;
            end else begin
               w_rsp_valid_nxt = 1'b0;
            end
         end
         ST_LOAD_DATA: begin
            w_rsp_valid_nxt = 1'b1;
            w_rsp_rdata_nxt = w_load_data;
         end
         ST_MERGE, ST_WRITE: w_rsp_valid_nxt = 1'b1;
         default:            w_rsp_valid_nxt = 1'b0;
      endcase

      w_req_ready_nxt    = (w_state_nxt == ST_IDLE);
      w_mem_read_en_nxt  = (w_state_nxt == ST_READ);
      w_mem_write_en_nxt = (w_state_nxt == ST_WRITE) || (w_state_nxt == ST_MERGE);

      if (w_state_nxt == ST_IDLE) begin
         w_mem_address_nxt = 32'h0000_0000;
      end else if (w_accept) begin
         w_mem_address_nxt = {req_addr[31:2], 2'b00};
      end else begin
         w_mem_address_nxt = r_mem_address;
      end

      if (w_accept && (w_state_nxt == ST_WRITE)) begin
         w_mem_write_data_nxt = req_wdata;
      end else begin
         w_mem_write_data_nxt = 32'h0000_0000;
      end
   end

   // Output registers; reset drops the memory enables immediately.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_req_ready      <= 1'b1;
         r_rsp_valid      <= 1'b0;
         r_rsp_error      <= 1'b0;
         r_rsp_rdata      <= 32'h0000_0000;
         r_mem_read_en    <= 1'b0;
         r_mem_write_en   <= 1'b0;
         r_mem_address    <= 32'h0000_0000;
         r_mem_write_data <= 32'h0000_0000;
      end else begin
         r_req_ready      <= w_req_ready_nxt;
         r_rsp_valid      <= w_rsp_valid_nxt;
         r_rsp_error      <= w_rsp_error_nxt;
         r_rsp_rdata      <= w_rsp_rdata_nxt;
         r_mem_read_en    <= w_mem_read_en_nxt;
         r_mem_write_en   <= w_mem_write_en_nxt;
         r_mem_address    <= w_mem_address_nxt;
         r_mem_write_data <= w_mem_write_data_nxt;
      end
   end

   // Request capture on acceptance; held for the rest of the transaction.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_write  <= 1'b0;
         r_funct3 <= 3'b000;
         r_addr   <= 32'h0000_0000;
         r_wdata  <= 32'h0000_0000;
      end else if (w_accept) begin
         r_write  <= req_write;
         r_funct3 <= req_funct3;
         r_addr   <= req_addr;
         r_wdata  <= req_wdata;
      end else begin
         r_write  <= r_write;
         r_funct3 <= r_funct3;
         r_addr   <= r_addr;
         r_wdata  <= r_wdata;
      end
   end

   assign req_ready    = r_req_ready;
   assign rsp_valid    = r_rsp_valid;
   assign rsp_error    = r_rsp_error;
   assign rsp_rdata    = r_rsp_rdata;
   assign mem_read_en  = r_mem_read_en;
   assign mem_write_en = r_mem_write_en;
   assign mem_address  = r_mem_address;
   // Merged word depends on read data that only arrives in the MERGE cycle.
   assign mem_write_data = (r_state == ST_MERGE) ? w_store_data : r_mem_write_data;

endmodule

// File: tb/tb_riscv_lsu_adapter.sv
// Scoreboard bench for riscv_lsu_adapter with a synchronous-read memory model.
module tb_riscv_lsu_adapter;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_error;
   logic [31:0] rsp_rdata;
   logic        mem_read_en;
   logic        mem_write_en;
   logic [31:0] mem_address;
   logic [31:0] mem_write_data;
   logic [31:0] mem_read_data;

   riscv_lsu_adapter dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_write      (req_write),
      .req_funct3     (req_funct3),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .rsp_valid      (rsp_valid),
      .rsp_error      (rsp_error),
      .rsp_rdata      (rsp_rdata),
      .mem_read_en    (mem_read_en),
      .mem_write_en   (mem_write_en),
      .mem_address    (mem_address),
      .mem_write_data (mem_write_data),
      .mem_read_data  (mem_read_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          acc;
   } exp_t;

   exp_t        q[$];
   int          n_vec = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          n_rd = 0;
   int          n_wr = 0;
   int          last_wcyc = 0;
   logic [31:0] last_wdata = 32'h0;
   logic [31:0] last_waddr = 32'h0;
   logic [31:0] mem [0:255];
   logic [31:0] shadow [0:255];
   bit          preload = 1'b1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w);
      logic [31:0] b;
      logic [31:0] h;
      b = w >> (8 * off);
      h = w >> (16 * off[1]);
      case (f3)
         3'b000:  return {{24{b[7]}}, b[7:0]};
         3'b100:  return {24'h0, b[7:0]};
         3'b001:  return {{16{h[15]}}, h[15:0]};
         3'b101:  return {16'h0, h[15:0]};
         3'b010:  return w;
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] model_store(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] old, input logic [31:0] wd);
      logic [31:0] mask;
      logic [31:0] sh;
      if (f3 == 3'b000) begin
         mask = 32'h0000_00FF << (8 * off);
         sh   = wd << (8 * off);
      end else if (f3 == 3'b001) begin
         mask = 32'h0000_FFFF << (16 * off[1]);
         sh   = wd << (16 * off[1]);
      end else begin
         mask = 32'hFFFF_FFFF;
         sh   = wd;
      end
      return (old & ~mask) | (sh & mask);
   endfunction

   function automatic bit model_err(input logic wr, input logic [2:0] f3, input logic [1:0] lo);
      bit legal;
      bit misal;
      legal = wr ? (f3 inside {3'b000, 3'b001, 3'b010})
                 : (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      misal = ((f3 == 3'b001 || f3 == 3'b101) && lo[0]) || (f3 == 3'b010 && lo != 2'b00);
      return !legal || misal;
   endfunction

   // Memory model: synchronous read, write on posedge.
   always @(posedge clk) begin
      if (preload) begin
         mem[8'h04] <= 32'h8899_AABB;
         mem[8'h08] <= 32'h1122_3344;
      end else begin
         if (mem_write_en) mem[mem_address[9:2]] <= mem_write_data;
         if (mem_read_en) mem_read_data <= mem[mem_address[9:2]];
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (mem_read_en) n_rd <= n_rd + 1;
      if (mem_write_en) begin
         n_wr       <= n_wr + 1;
         last_wcyc  <= cyc;
         last_wdata <= mem_write_data;
         last_waddr <= mem_address;
      end
   end

   // Response monitor: pop the scoreboard on every rsp_valid pulse.
   always @(negedge clk) begin
      if (rst && rsp_valid) begin
         if (q.size() == 0) begin
            chk("unexpected_rsp", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_error", {31'd0, rsp_error}, {31'd0, e.err});
            chk("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
         end
      end
   end

   task automatic send(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input bit track, output int acc, output bit rv);
      bit   ok;
      bit   err;
      exp_t e;
      req_valid  = 1'b1;
      req_write  = wr;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      ok  = 1'b0;
      rv  = 1'b0;
      acc = 0;
      for (int k = 0; k < 50; k++) begin
         if (req_ready) begin
            rv = rsp_valid;
            @(posedge clk);
            #1;
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         chk("accept_timeout", 32'd0, 32'd1);
         return;
      end
      acc = cyc - 1;
      if (track) begin
         err     = model_err(wr, f3, addr[1:0]);
         e.err   = err;
         e.acc   = acc;
         e.lat   = err ? 1 : ((wr && f3 == 3'b010) ? 2 : 3);
         e.rdata = (err || wr) ? 32'h0 : model_load(f3, addr[1:0], shadow[addr[9:2]]);
         q.push_back(e);
         if (wr && !err)
            shadow[addr[9:2]] = model_store(f3, addr[1:0], shadow[addr[9:2]], wd);
      end
   endtask

   task automatic idle(input int n);
      req_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int acc;
      bit rv;
      int rd0;
      int wr0;
      rst        = 1'b0;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_funct3 = 3'b000;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      shadow[8'h04] = 32'h8899_AABB;
      shadow[8'h08] = 32'h1122_3344;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rsp_error", {31'd0, rsp_error}, 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk("rst_mem_read_en", {31'd0, mem_read_en}, 32'd0);
      chk("rst_mem_write_en", {31'd0, mem_write_en}, 32'd0);
      chk("rst_mem_address", mem_address, 32'h0);
      chk("rst_mem_write_data", mem_write_data, 32'h0);
      preload = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Byte loads, signed and unsigned
      send(1'b0, 3'b000, 32'h11, 32'h0, 1'b1, acc, rv); idle(4);
      send(1'b0, 3'b100, 32'h11, 32'h0, 1'b1, acc, rv); idle(4);

      // Sub-word store via read-modify-write
      send(1'b1, 3'b000, 32'h22, 32'h0000_00EE, 1'b1, acc, rv); idle(4);
      chk("sb_merge_wdata", last_wdata, 32'h11EE_3344);
      chk("sb_write_latency", 32'(last_wcyc - acc), 32'd2);
      chk("sb_write_addr", last_waddr, 32'h20);
      send(1'b0, 3'b010, 32'h20, 32'h0, 1'b1, acc, rv); idle(4);

      // Word store: no read, single write cycle
      rd0 = n_rd;
      send(1'b1, 3'b010, 32'h40, 32'hDEAD_BEEF, 1'b1, acc, rv); idle(4);
      chk("sw_no_read", 32'(n_rd - rd0), 32'd0);
      chk("sw_write_latency", 32'(last_wcyc - acc), 32'd1);
      chk("sw_wdata", last_wdata, 32'hDEAD_BEEF);
      send(1'b0, 3'b001, 32'h42, 32'h0, 1'b1, acc, rv); idle(4);

      // Halfword store then unsigned/word readback
      send(1'b1, 3'b001, 32'h22, 32'h1234_ABCD, 1'b1, acc, rv); idle(4);
      send(1'b0, 3'b101, 32'h22, 32'h0, 1'b1, acc, rv); idle(4);
      send(1'b0, 3'b010, 32'h20, 32'h0, 1'b1, acc, rv); idle(4);
      send(1'b0, 3'b000, 32'h43, 32'h0, 1'b1, acc, rv); idle(4);

      // Error cases: no memory traffic at all
      rd0 = n_rd;
      wr0 = n_wr;
      send(1'b0, 3'b010, 32'h41, 32'h0, 1'b1, acc, rv); idle(3);
      send(1'b1, 3'b001, 32'h43, 32'h5555, 1'b1, acc, rv); idle(3);
      send(1'b1, 3'b100, 32'h40, 32'h77, 1'b1, acc, rv); idle(3);
      send(1'b0, 3'b011, 32'h40, 32'h0, 1'b1, acc, rv); idle(3);
      chk("err_no_read", 32'(n_rd - rd0), 32'd0);
      chk("err_no_write", 32'(n_wr - wr0), 32'd0);

      // Back-to-back SW then LW with req_valid held
      send(1'b1, 3'b010, 32'h30, 32'hCAFE_F00D, 1'b1, acc, rv);
      send(1'b0, 3'b010, 32'h30, 32'h0, 1'b1, acc, rv);
      chk("b2b_accept_in_rsp_cycle", {31'd0, rv}, 32'd1);
      idle(4);

      // Reset during MERGE of an SB
      send(1'b1, 3'b000, 32'h10, 32'h0000_0055, 1'b0, acc, rv);
      req_valid = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (mem_write_en) break;
      end
      #2;
      rst = 1'b0;
      #1;
      chk("rst_merge_write_en", {31'd0, mem_write_en}, 32'd0);
      chk("rst_merge_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_merge_req_ready", {31'd0, req_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      idle(4);
      chk("rst_merge_mem_kept", mem[8'h04], 32'h8899_AABB);
      chk("rst_merge_ready_after", {31'd0, req_ready}, 32'd1);
      send(1'b0, 3'b010, 32'h10, 32'h0, 1'b1, acc, rv); idle(4);

      for (int k = 0; k < 50; k++) begin
         if (q.size() == 0) break;
         @(posedge clk);
      end
      chk("scoreboard_drained", 32'(q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
